// File: rtl/count_down.sv
// Loadable down-counter with one-cycle done pulse and pause support.
// Optional periodic mode: define COUNT_DOWN_AUTO_RELOAD_EN to reload the start value on terminal count.
module count_down #(
    parameter int IN_W  = 5,
    parameter int OUT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  cntin,
    input  logic             load,
    input  logic             enable,
    output logic [OUT_W-1:0] cntout,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t state;

`ifdef COUNT_DOWN_AUTO_RELOAD_EN
    logic [IN_W-1:0] reload;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cntout <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef COUNT_DOWN_AUTO_RELOAD_EN
            reload <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (load) begin
                cntout <= OUT_W'(cntin);
`ifdef COUNT_DOWN_AUTO_RELOAD_EN
                reload <= cntin;
`endif
                if (cntin != '0) begin
                    state <= RUN;
                    busy  <= 1'b1;
                end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end else begin
                case (state)
                    RUN, PAUSE: begin
                        // Resuming from PAUSE decrements on the same edge.
                        if (enable) begin
                            if (cntout > OUT_W'(1)) begin
                                cntout <= cntout - OUT_W'(1);
                                state  <= RUN;
                                busy   <= 1'b1;
                            end else begin
                                done <= 1'b1;
`ifdef COUNT_DOWN_AUTO_RELOAD_EN
                                cntout <= OUT_W'(reload);
                                state  <= RUN;
                                busy   <= 1'b1;
`else
                                cntout <= '0;
                                state  <= IDLE;
                                busy   <= 1'b0;
`endif
                            end
                        end else begin
                            state <= PAUSE;
                            busy  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_count_down.sv
// Directed self-checking bench for count_down with hand-computed expected sequences.
module tb_count_down;

    logic       clk;
    logic       rst;
    logic [4:0] cntin;
    logic       load;
    logic       enable;
    logic [5:0] cntout;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    count_down #(.IN_W(5), .OUT_W(6)) dut (
        .clk    (clk),
        .rst    (rst),
        .cntin  (cntin),
        .load   (load),
        .enable (enable),
        .cntout (cntout),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input int c, input logic b, input logic d);
        chk({tag, ".cntout"}, 32'(cntout), 32'(c));
        chk({tag, ".busy"},   32'(busy),   32'(b));
        chk({tag, ".done"},   32'(done),   32'(d));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; load = 1'b0; enable = 1'b0; cntin = '0;
        #12;
        chk3("reset", 0, 1'b0, 1'b0);
        rst = 1'b1;

        // Async reset mid-count at 7
        cntin = 5'd9; load = 1'b1; enable = 1'b1;
        tick;
        load = 1'b0;
        chk3("t1.load", 9, 1'b1, 1'b0);
        tick;
        tick;
        chk3("t1.at7", 7, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1 chk3("t1.async", 0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        tick;
        chk3("t1.idle", 0, 1'b0, 1'b0);

`ifndef COUNT_DOWN_AUTO_RELOAD_EN
        // Load 5, count to zero
        cntin = 5'd5; load = 1'b1; enable = 1'b1;
        tick;
        load = 1'b0;
        chk3("t2.load", 5, 1'b1, 1'b0);
        for (int k = 4; k >= 1; k--) begin
            tick;
            chk3("t2.run", k, 1'b1, 1'b0);
        end
        tick;
        chk3("t2.term", 0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick;
            chk3("t2.hold", 0, 1'b0, 1'b0);
        end

        // Load 4 with enable 1,1,0,0,1,1
        cntin = 5'd4; load = 1'b1; enable = 1'b1;
        tick;
        load = 1'b0;
        chk3("t3.load", 4, 1'b1, 1'b0);
        enable = 1'b1; tick; chk3("t3.e1", 3, 1'b1, 1'b0);
        enable = 1'b1; tick; chk3("t3.e2", 2, 1'b1, 1'b0);
        enable = 1'b0; tick; chk3("t3.p1", 2, 1'b1, 1'b0);
        enable = 1'b0; tick; chk3("t3.p2", 2, 1'b1, 1'b0);
        enable = 1'b1; tick; chk3("t3.r1", 1, 1'b1, 1'b0);
        enable = 1'b1; tick; chk3("t3.term", 0, 1'b0, 1'b1);
        tick;              chk3("t3.after", 0, 1'b0, 1'b0);
`endif

        // Load of zero stays idle, never pulses done
        cntin = 5'd0; load = 1'b1; enable = 1'b1;
        tick;
        load = 1'b0;
        chk3("t4.load0", 0, 1'b0, 1'b0);
        tick;
        chk3("t4.idle1", 0, 1'b0, 1'b0);
        tick;
        chk3("t4.idle2", 0, 1'b0, 1'b0);

        // Load wins over terminal decrement
        cntin = 5'd1; load = 1'b1; enable = 1'b1;
        tick;
        chk3("t5.at1", 1, 1'b1, 1'b0);
        cntin = 5'd21; load = 1'b1; enable = 1'b1;
        tick;
        load = 1'b0; enable = 1'b0;
        chk3("t5.loadwin", 21, 1'b1, 1'b0);
        tick;
        chk3("t5.pause", 21, 1'b1, 1'b0);
        enable = 1'b1;
        tick;
        chk3("t5.resume", 20, 1'b1, 1'b0);

`ifdef COUNT_DOWN_AUTO_RELOAD_EN
        // Periodic reload of 3
        cntin = 5'd3; load = 1'b1; enable = 1'b1;
        tick;
        load = 1'b0;
        chk3("t6.load", 3, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            tick;
            case (k % 3)
                0: chk3("t6.run", 2, 1'b1, 1'b0);
                1: chk3("t6.run", 1, 1'b1, 1'b0);
                default: chk3("t6.reload", 3, 1'b1, 1'b1);
            endcase
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
